// File: rtl/p405s_icu_va_flash_seq_if.sv
// p405s_icu_va_flash_seq_if: ICU-control-side bundle for the valid-bit flash sequencer
interface p405s_icu_va_flash_seq_if #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W = 3
);
    logic                   vaWrCycle;
    logic [IDX_W-1:0]       vaWrIndex;
    logic                   vaWrData;
    logic                   wrFlash;
    logic [IDX_W-1:0]       vaRdIndex;
    logic                   vaRdValid;
    logic [NUM_ENTRIES-1:0] vaValid;
    logic [NUM_ENTRIES-1:0] vaE2;
    logic                   vaWrStall;
    logic                   flashBusy;
    logic                   flashDone;

    modport master (
        output vaWrCycle, vaWrIndex, vaWrData, wrFlash, vaRdIndex,
        input  vaRdValid, vaValid, vaE2, vaWrStall, flashBusy, flashDone
    );

    modport slave (
        input  vaWrCycle, vaWrIndex, vaWrData, wrFlash, vaRdIndex,
        output vaRdValid, vaValid, vaE2, vaWrStall, flashBusy, flashDone
    );
endinterface

// File: rtl/p405s_icu_va_flash_seq.sv
// p405s_icu_va_flash_seq: I-cache valid-bit array with per-entry writes and single-cycle or banked flash invalidate
module p405s_icu_va_flash_seq #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W = 3,
    parameter int BANK_SIZE = 4,
    parameter bit FLASH_MODE = 1'b1
) (
    input logic CB,
    input logic resetN,
    p405s_icu_va_flash_seq_if.slave va
);
    localparam int NUM_BANKS = NUM_ENTRIES / BANK_SIZE;
    localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    localparam logic [NUM_ENTRIES-1:0] BANK0 = {NUM_ENTRIES{1'b1}} >> (NUM_ENTRIES - BANK_SIZE);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                 state;
    logic                   pending;
    logic [BANK_W-1:0]      bank;
    logic [NUM_ENTRIES-1:0] valid;
    logic [NUM_ENTRIES-1:0] e2;
    logic                   busy;
    logic                   done;
    logic                   wr_go;
    logic                   last_bank;
    logic [NUM_ENTRIES-1:0] next_mask;

    // bank 0 is cleared on the edge that enters SWEEP, so each SWEEP cycle shows its own bank on vaE2
    assign next_mask = BANK0 << (BANK_SIZE * (int'(bank) + 1));
    assign last_bank = bank == BANK_W'(NUM_BANKS - 1);
    assign va.vaWrStall = va.vaWrCycle & (va.wrFlash | busy | state == DONE);
    assign wr_go = va.vaWrCycle & ~va.vaWrStall;
    assign va.vaRdValid = valid[va.vaRdIndex] & ~busy;
    assign va.vaValid = valid;
    assign va.vaE2 = e2;
    assign va.flashBusy = busy;
    assign va.flashDone = done;

    // flash sequencer and valid array; vaE2 and flashDone default to zero every cycle
    always_ff @(posedge CB or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            pending <= 1'b0;
            bank    <= '0;
            valid   <= '0;
            e2      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            e2   <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (va.wrFlash) begin
                        if (FLASH_MODE) begin
                            state <= SWEEP;
                            busy  <= 1'b1;
                            bank  <= '0;
                            valid <= valid & ~BANK0;
                            e2    <= BANK0;
                        end else begin
                            state <= DONE;
                            valid <= '0;
                            e2    <= '1;
                        end
                    end else if (wr_go) begin
                        valid[va.vaWrIndex] <= va.vaWrData;
                        e2[va.vaWrIndex]    <= 1'b1;
                    end
                end
                SWEEP: begin
                    pending <= pending | va.wrFlash;
                    if (last_bank) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bank  <= '0;
                    end else begin
                        bank  <= bank + 1'b1;
                        valid <= valid & ~next_mask;
                        e2    <= next_mask;
                    end
                end
                DONE: begin
                    if (!FLASH_MODE) done <= 1'b1;
                    if (pending | va.wrFlash) begin
                        pending <= 1'b0;
                        if (FLASH_MODE) begin
                            state <= SWEEP;
                            busy  <= 1'b1;
                            bank  <= '0;
                            valid <= valid & ~BANK0;
                            e2    <= BANK0;
                        end else begin
                            valid <= '0;
                            e2    <= '1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_p405s_icu_va_flash_seq.sv
// tb_p405s_icu_va_flash_seq: three configurations driven in lockstep against a cycle-scheduled reference model
module tb_p405s_icu_va_flash_seq;
    localparam int MAXC = 2048;
    localparam int NI = 3;
    localparam int MODE [NI] = '{1, 0, 1};
    localparam int BSZ [NI] = '{4, 4, 8};

    logic       CB = 1'b0;
    logic       resetN = 1'b0;
    logic       wr_cycle = 1'b0;
    logic [2:0] wr_idx = '0;
    logic       wr_data = 1'b0;
    logic       wr_flash = 1'b0;
    logic [2:0] rd_idx = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit [7:0] e2_at [NI][MAXC];
    bit [7:0] clr_at [NI][MAXC];
    bit       busy_at [NI][MAXC];
    bit       win_at [NI][MAXC];
    bit       done_at [NI][MAXC];
    bit       end_at [NI][MAXC];
    bit       pend [NI];
    bit [7:0] val [NI];

    logic [7:0] o_e2 [NI];
    logic [7:0] o_val [NI];
    logic       o_busy [NI];
    logic       o_done [NI];
    logic       o_stall [NI];
    logic       o_rdv [NI];

    p405s_icu_va_flash_seq_if #(.NUM_ENTRIES(8), .IDX_W(3)) va0 ();
    p405s_icu_va_flash_seq_if #(.NUM_ENTRIES(8), .IDX_W(3)) va1 ();
    p405s_icu_va_flash_seq_if #(.NUM_ENTRIES(8), .IDX_W(3)) va2 ();

    p405s_icu_va_flash_seq #(.NUM_ENTRIES(8), .IDX_W(3), .BANK_SIZE(4), .FLASH_MODE(1'b1)) u_sweep (.CB(CB), .resetN(resetN), .va(va0));
    p405s_icu_va_flash_seq #(.NUM_ENTRIES(8), .IDX_W(3), .BANK_SIZE(4), .FLASH_MODE(1'b0)) u_flash (.CB(CB), .resetN(resetN), .va(va1));
    p405s_icu_va_flash_seq #(.NUM_ENTRIES(8), .IDX_W(3), .BANK_SIZE(8), .FLASH_MODE(1'b1)) u_whole (.CB(CB), .resetN(resetN), .va(va2));

    assign va0.vaWrCycle = wr_cycle;
    assign va0.vaWrIndex = wr_idx;
    assign va0.vaWrData = wr_data;
    assign va0.wrFlash = wr_flash;
    assign va0.vaRdIndex = rd_idx;
    assign va1.vaWrCycle = wr_cycle;
    assign va1.vaWrIndex = wr_idx;
    assign va1.vaWrData = wr_data;
    assign va1.wrFlash = wr_flash;
    assign va1.vaRdIndex = rd_idx;
    assign va2.vaWrCycle = wr_cycle;
    assign va2.vaWrIndex = wr_idx;
    assign va2.vaWrData = wr_data;
    assign va2.wrFlash = wr_flash;
    assign va2.vaRdIndex = rd_idx;

    assign o_e2[0] = va0.vaE2;
    assign o_e2[1] = va1.vaE2;
    assign o_e2[2] = va2.vaE2;
    assign o_val[0] = va0.vaValid;
    assign o_val[1] = va1.vaValid;
    assign o_val[2] = va2.vaValid;
    assign o_busy[0] = va0.flashBusy;
    assign o_busy[1] = va1.flashBusy;
    assign o_busy[2] = va2.flashBusy;
    assign o_done[0] = va0.flashDone;
    assign o_done[1] = va1.flashDone;
    assign o_done[2] = va2.flashDone;
    assign o_stall[0] = va0.vaWrStall;
    assign o_stall[1] = va1.vaWrStall;
    assign o_stall[2] = va2.vaWrStall;
    assign o_rdv[0] = va0.vaRdValid;
    assign o_rdv[1] = va1.vaRdValid;
    assign o_rdv[2] = va2.vaRdValid;

    always #5 CB = ~CB;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            pend[i] = 1'b0;
            val[i] = '0;
            for (int c = 0; c < MAXC; c++) begin
                e2_at[i][c] = '0;
                clr_at[i][c] = '0;
                busy_at[i][c] = 1'b0;
                win_at[i][c] = 1'b0;
                done_at[i][c] = 1'b0;
                end_at[i][c] = 1'b0;
            end
        end
    endtask

    // a flash accepted in cycle c books every visible effect into the future cycle tables
    task automatic start_flash(input int i, input int c);
        int k;
        bit [7:0] m;
        if (MODE[i] == 1) begin
            k = 8 / BSZ[i];
            for (int b = 0; b < k; b++) begin
                m = 8'(((1 << BSZ[i]) - 1) << (b * BSZ[i]));
                busy_at[i][c+1+b] = 1'b1;
                win_at[i][c+1+b] = 1'b1;
                e2_at[i][c+1+b] |= m;
                clr_at[i][c+1+b] |= m;
            end
            win_at[i][c+k+1] = 1'b1;
            end_at[i][c+k+1] = 1'b1;
            done_at[i][c+k+1] = 1'b1;
        end else begin
            win_at[i][c+1] = 1'b1;
            end_at[i][c+1] = 1'b1;
            e2_at[i][c+1] = 8'hFF;
            clr_at[i][c+1] = 8'hFF;
            done_at[i][c+2] = 1'b1;
        end
    endtask

    task automatic model_tick(input int c);
        bit eff;
        for (int i = 0; i < NI; i++) begin
            if (win_at[i][c]) begin
                eff = pend[i] | wr_flash;
                if (end_at[i][c]) begin
                    pend[i] = 1'b0;
                    if (eff) start_flash(i, c);
                end else begin
                    pend[i] = eff;
                end
            end else if (wr_flash) begin
                start_flash(i, c);
            end else if (wr_cycle) begin
                val[i][wr_idx] = wr_data;
                e2_at[i][c+1] |= 8'(1 << wr_idx);
            end
            val[i] &= ~clr_at[i][c+1];
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d c%0d vaE2", i, cyc), 32'(o_e2[i]), 32'(e2_at[i][cyc]));
            chk($sformatf("u%0d c%0d vaValid", i, cyc), 32'(o_val[i]), 32'(val[i]));
            chk($sformatf("u%0d c%0d flashBusy", i, cyc), 32'(o_busy[i]), 32'(busy_at[i][cyc]));
            chk($sformatf("u%0d c%0d flashDone", i, cyc), 32'(o_done[i]), 32'(done_at[i][cyc]));
            chk($sformatf("u%0d c%0d vaWrStall", i, cyc), 32'(o_stall[i]), 32'(wr_cycle & (wr_flash | win_at[i][cyc])));
            chk($sformatf("u%0d c%0d vaRdValid", i, cyc), 32'(o_rdv[i]), 32'(val[i][rd_idx] & ~busy_at[i][cyc]));
        end
    endtask

    task automatic check_zero(input string why);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d %s vaE2", i, why), 32'(o_e2[i]), 32'd0);
            chk($sformatf("u%0d %s vaValid", i, why), 32'(o_val[i]), 32'd0);
            chk($sformatf("u%0d %s flashBusy", i, why), 32'(o_busy[i]), 32'd0);
            chk($sformatf("u%0d %s flashDone", i, why), 32'(o_done[i]), 32'd0);
            chk($sformatf("u%0d %s vaRdValid", i, why), 32'(o_rdv[i]), 32'd0);
        end
    endtask

    task automatic step();
        @(negedge CB);
        check_all();
        @(posedge CB);
        model_tick(cyc);
        cyc++;
        #1;
    endtask

    task automatic drive(input bit wc, input int idx, input bit d, input bit wf, input int rd);
        wr_cycle = wc;
        wr_idx = 3'(idx);
        wr_data = d;
        wr_flash = wf;
        rd_idx = 3'(rd);
        step();
    endtask

    task automatic idle(input int n, input int rd);
        for (int j = 0; j < n; j++) drive(1'b0, 0, 1'b0, 1'b0, rd);
    endtask

    task automatic fill();
        for (int j = 0; j < 8; j++) drive(1'b1, j, 1'b1, 1'b0, j);
    endtask

    // asynchronous reset asserted mid-cycle, released just after an edge
    task automatic do_reset();
        wr_cycle = 1'b0;
        wr_flash = 1'b0;
        #2 resetN = 1'b0;
        #1 check_zero("async_reset");
        @(posedge CB);
        #1 resetN = 1'b1;
        clear_model();
        cyc = 0;
    endtask

    initial begin
        clear_model();
        repeat (2) @(posedge CB);
        #1 check_zero("in_reset");
        resetN = 1'b1;
        cyc = 0;
        idle(2, 0);
        drive(1'b1, 5, 1'b1, 1'b0, 5);
        idle(3, 5);
        fill();
        drive(1'b0, 0, 1'b0, 1'b1, 7);
        idle(5, 3);
        drive(1'b1, 2, 1'b1, 1'b1, 2);
        idle(5, 2);
        fill();
        drive(1'b0, 0, 1'b0, 1'b1, 1);
        drive(1'b0, 0, 1'b0, 1'b1, 1);
        drive(1'b1, 6, 1'b1, 1'b1, 1);
        idle(9, 1);
        fill();
        drive(1'b0, 0, 1'b0, 1'b1, 4);
        drive(1'b1, 4, 1'b1, 1'b0, 4);
        do_reset();
        drive(1'b1, 3, 1'b1, 1'b0, 3);
        idle(4, 3);
        do_reset();
        for (int n = 0; n < 800; n++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  $urandom_range(0, 11) == 0, int'($urandom_range(0, 7)));
        end
        idle(6, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
